// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared fetch-side definitions: opcode constants, instruction field positions and FSM states.
package instr_fetch_ctrl_pkg;

    localparam logic [3:0] OP_BCOND  = 4'hC;
    localparam logic [3:0] OP_JCOND  = 4'h4;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned COND_LSB = 8;
    localparam int unsigned EXT_LSB  = 4;
    localparam int unsigned DISP_LSB = 0;
    localparam int unsigned RS_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StUpdate
    } fetch_state_e;

    function automatic logic is_bcond(logic [15:0] instr);
        return instr[OP_LSB +: 4] == OP_BCOND;
    endfunction

    function automatic logic is_jcond(logic [15:0] instr);
        return (instr[OP_LSB +: 4] == OP_JCOND) && (instr[EXT_LSB +: 4] == EXT_JCOND);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of PC control, register/flag lookup, instruction memory and decoder signals.
interface instr_fetch_ctrl_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned IW = 16
);
    logic [AW-1:0] pc_addr;
    logic          pc_en;
    logic          pc_jump;
    logic          pc_branch;
    logic [7:0]    pc_disp;
    logic [AW-1:0] pc_rdest;
    logic [3:0]    reg_raddr;
    logic [AW-1:0] reg_rdata;
    logic [3:0]    cond_code;
    logic          cond_true;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [IW-1:0] mem_rdata;
    logic          dec_valid;
    logic [IW-1:0] dec_instr;
    logic          dec_ready;

    modport master (
        input  pc_addr, reg_rdata, cond_true, mem_gnt, mem_rvalid, mem_rdata, dec_ready,
        output pc_en, pc_jump, pc_branch, pc_disp, pc_rdest, reg_raddr, cond_code,
        output mem_req, mem_addr, dec_valid, dec_instr
    );

    modport slave (
        output pc_addr, reg_rdata, cond_true, mem_gnt, mem_rvalid, mem_rdata, dec_ready,
        input  pc_en, pc_jump, pc_branch, pc_disp, pc_rdest, reg_raddr, cond_code,
        input  mem_req, mem_addr, dec_valid, dec_instr
    );

endinterface

// File: rtl/instr_fetch_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry whenever empty is low.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; entries are only observed after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    assign dout  = mem_q[rptr_q];
    assign full  = count_q == (PW + 1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: one outstanding instruction read, buffered for the decoder, with PC feedback.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned IW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_ctrl_if.master  bus_io
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [IW-1:0] instr_q, instr_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [IW-1:0] fifo_dout;
    logic          fetch_ok;
    logic          instr_branch, instr_jump;

    assign fetch_ok     = fifo_count < CW'(DEPTH);
    assign instr_branch = is_bcond(instr_q[15:0]);
    assign instr_jump   = is_jcond(instr_q[15:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        unique case (state_q)
            StIdle: begin
                if (fetch_ok) begin
                    mem_addr_d = bus_io.pc_addr;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (bus_io.mem_gnt) state_d = StWait;
            end
            StWait: begin
                if (bus_io.mem_rvalid) begin
                    instr_d = bus_io.mem_rdata;
                    state_d = StUpdate;
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_io.mem_req   = state_q == StReq;
        bus_io.mem_addr  = mem_addr_q;
        bus_io.pc_en     = 1'b0;
        bus_io.pc_jump   = 1'b0;
        bus_io.pc_branch = 1'b0;
        bus_io.pc_rdest  = '0;
        bus_io.pc_disp   = instr_q[DISP_LSB +: 8];
        bus_io.reg_raddr = instr_q[RS_LSB +: 4];
        bus_io.cond_code = instr_q[COND_LSB +: 4];
        // Register and flag lookups are combinational, so the decision lands in the UPDATE cycle.
        if (state_q == StUpdate) begin
            bus_io.pc_en     = 1'b1;
            bus_io.pc_branch = instr_branch && bus_io.cond_true;
            bus_io.pc_jump   = instr_jump && bus_io.cond_true;
            if (instr_jump) bus_io.pc_rdest = bus_io.reg_rdata;
        end
    end

    // Late read data after a reset is dropped because only WAIT may push.
    assign fifo_push        = (state_q == StWait) && bus_io.mem_rvalid;
    assign fifo_pop         = !fifo_empty && bus_io.dec_ready;
    assign bus_io.dec_valid = !fifo_empty;
    assign bus_io.dec_instr = fifo_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (bus_io.mem_rdata),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: memory agent, PC model and decoder-queue model around the DUT.
module tb_instr_fetch_ctrl;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;

    instr_fetch_ctrl_if #(.AW(16), .IW(16)) bus ();

    instr_fetch_ctrl #(
        .DEPTH (DEPTH),
        .AW    (16),
        .IW    (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks;
    int errors;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] q [$];
    logic [15:0] pc;

    bit          pending;
    logic [15:0] pend_addr;
    int          rv_cnt, gnt_cnt, gnt_delay, rv_delay;
    int          cond_mode, rd_mode, ready_mode;
    logic [15:0] rd_force;
    bit          cond_now;

    bit          upd_due;
    logic [15:0] upd_instr, upd_addr;
    bit          prev_req;
    logic [15:0] prev_mem_addr, prev_pc;
    int          prev_qsize;
    int          n_upd, cyc, last_upd_cyc, prev_upd_cyc;

    logic        last_br, last_jp;
    logic [7:0]  last_disp;
    logic [15:0] last_rdest, last_addr, last_pop;
    logic [3:0]  last_raddr, last_cc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    task automatic check_reset_outputs(string tag);
        chk({tag, "_pc_en"},     32'(bus.pc_en), 32'(0));
        chk({tag, "_pc_jump"},   32'(bus.pc_jump), 32'(0));
        chk({tag, "_pc_branch"}, 32'(bus.pc_branch), 32'(0));
        chk({tag, "_mem_req"},   32'(bus.mem_req), 32'(0));
        chk({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'(0));
        chk({tag, "_pc_disp"},   32'(bus.pc_disp), 32'(0));
        chk({tag, "_pc_rdest"},  32'(bus.pc_rdest), 32'(0));
        chk({tag, "_mem_addr"},  32'(bus.mem_addr), 32'(0));
        chk({tag, "_reg_raddr"}, 32'(bus.reg_raddr), 32'(0));
        chk({tag, "_cond_code"}, 32'(bus.cond_code), 32'(0));
    endtask

    // One clock: drive memory/decoder/PC inputs, then compare against the models.
    task automatic cycle();
        logic [15:0] ddata, daddr, drv_pc;
        logic [3:0]  op;
        bit          delivered, busy, exp_br, exp_jp;
        int          qs;
        @(posedge clk);
        #1;
        cyc++;
        delivered = 1'b0;
        ddata     = 16'h0;
        daddr     = 16'h0;
        busy      = pending || upd_due;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'($urandom);
        if (pending) begin
            if (rv_cnt == 0) begin
                ddata          = mem_rd(pend_addr);
                daddr          = pend_addr;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = ddata;
                delivered      = 1'b1;
                pending        = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (bus.mem_req) begin
            if (!prev_req) gnt_cnt = gnt_delay;
            if (gnt_cnt == 0) begin
                bus.mem_gnt = 1'b1;
                pending     = 1'b1;
                pend_addr   = bus.mem_addr;
                rv_cnt      = rv_delay;
            end else begin
                gnt_cnt--;
            end
        end
        cond_now      = (cond_mode == 1) ? 1'b1 : (cond_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.cond_true = cond_now;
        bus.reg_rdata = (rd_mode == 1) ? rd_force : 16'($urandom);
        bus.dec_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0
                                                                      : 1'($urandom_range(0, 1));
        drv_pc      = pc;
        bus.pc_addr = pc;
        #1;
        qs = q.size();
        chk("pc_en", 32'(bus.pc_en), 32'(upd_due));
        if (upd_due) begin
            op     = upd_instr[15:12];
            exp_br = (op == 4'hC) && cond_now;
            exp_jp = (op == 4'h4) && (upd_instr[7:4] == 4'hC) && cond_now;
            chk("pc_branch", 32'(bus.pc_branch), 32'(exp_br));
            chk("pc_jump", 32'(bus.pc_jump), 32'(exp_jp));
            chk("pc_disp", 32'(bus.pc_disp), 32'(upd_instr & 16'h00FF));
            chk("cond_code", 32'(bus.cond_code), 32'((upd_instr >> 8) & 16'h000F));
            chk("reg_raddr", 32'(bus.reg_raddr), 32'(upd_instr & 16'h000F));
            if (exp_jp) chk("pc_rdest", 32'(bus.pc_rdest), 32'(bus.reg_rdata));
            last_br      = bus.pc_branch;
            last_jp      = bus.pc_jump;
            last_disp    = bus.pc_disp;
            last_rdest   = bus.pc_rdest;
            last_raddr   = bus.reg_raddr;
            last_cc      = bus.cond_code;
            last_addr    = upd_addr;
            n_upd++;
            prev_upd_cyc = last_upd_cyc;
            last_upd_cyc = cyc;
            if (exp_br)      pc = pc + {{8{upd_instr[7]}}, upd_instr[7:0]};
            else if (exp_jp) pc = bus.reg_rdata;
            else             pc = pc + 16'd1;
        end else begin
            chk("jb_idle", 32'({bus.pc_jump, bus.pc_branch}), 32'(0));
        end
        if (busy) chk("req_busy", 32'(bus.mem_req), 32'(0));
        if (bus.mem_req && !prev_req) begin
            chk("req_addr", 32'(bus.mem_addr), 32'(prev_pc));
            chk("req_room", 32'(prev_qsize < DEPTH), 32'(1));
        end
        if (bus.mem_req && prev_req) chk("req_hold", 32'(bus.mem_addr), 32'(prev_mem_addr));
        chk("dec_valid", 32'(bus.dec_valid), 32'(qs != 0));
        if (qs != 0) begin
            chk("dec_instr", 32'(bus.dec_instr), 32'(q[0]));
            if (bus.dec_ready) begin
                last_pop = bus.dec_instr;
                void'(q.pop_front());
            end
        end
        if (delivered) q.push_back(ddata);
        prev_qsize    = qs;
        prev_req      = bus.mem_req;
        prev_mem_addr = bus.mem_addr;
        prev_pc       = drv_pc;
        upd_due       = delivered;
        upd_instr     = ddata;
        upd_addr      = daddr;
    endtask

    task automatic run_fetches(int n, int budget, string tag);
        int start;
        int k;
        start = n_upd;
        k     = 0;
        while ((n_upd - start) < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 32'(n_upd - start), 32'(n));
    endtask

    initial begin
        int base;
        int expn;
        int k;
        checks = 0;
        errors = 0;
        pending = 1'b0;
        upd_due = 1'b0;
        gnt_delay = 0;
        rv_delay = 0;
        gnt_cnt = 0;
        rv_cnt = 0;
        cond_mode = 0;
        rd_mode = 0;
        ready_mode = 1;
        rd_force = 16'h0;
        n_upd = 0;
        cyc = 0;
        last_upd_cyc = 0;
        prev_upd_cyc = 0;
        pc = 16'h0010;
        reset = 1'b1;
        bus.pc_addr = pc;
        bus.reg_rdata = 16'hA5A5;
        bus.cond_true = 1'b1;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 16'h0;
        bus.dec_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        prev_pc = pc;
        prev_req = 1'b0;
        prev_qsize = 0;

        // Sequential fetch
        mem[16'h0010] = 16'h1234;
        run_fetches(1, 20, "seq_done");
        chk("seq_addr", 32'(last_addr), 32'h0010);
        chk("seq_instr", 32'(last_pop), 32'h1234);
        chk("seq_jb", 32'({last_jp, last_br}), 32'(0));

        // Taken and not-taken branch
        mem[16'h0011] = 16'hC105;
        cond_mode = 1;
        run_fetches(1, 20, "br_done");
        chk("fetch_period", 32'(last_upd_cyc - prev_upd_cyc), 32'(4));
        chk("br_taken", 32'(last_br), 32'(1));
        chk("br_disp", 32'(last_disp), 32'h05);
        chk("br_cc", 32'(last_cc), 32'h1);
        chk("br_nojump", 32'(last_jp), 32'(0));
        mem[16'h0016] = 16'hC105;
        cond_mode = 2;
        run_fetches(1, 20, "brn_done");
        chk("br_not_taken", 32'(last_br), 32'(0));
        chk("brn_addr", 32'(last_addr), 32'h0016);

        // Jump through register
        mem[16'h0017] = 16'h40C7;
        cond_mode = 1;
        rd_mode = 1;
        rd_force = 16'h0200;
        run_fetches(1, 20, "jmp_done");
        chk("jmp_raddr", 32'(last_raddr), 32'h7);
        chk("jmp_taken", 32'(last_jp), 32'(1));
        chk("jmp_rdest", 32'(last_rdest), 32'h0200);
        chk("jmp_nobranch", 32'(last_br), 32'(0));
        rd_mode = 0;
        cond_mode = 0;

        // Back-pressure: FIFO fills then fetching stops
        ready_mode = 2;
        base = n_upd;
        expn = DEPTH - q.size();
        repeat (40) cycle();
        chk("bp_fetches", 32'(n_upd - base), 32'(expn));
        chk("bp_req_low", 32'(bus.mem_req), 32'(0));
        chk("bp_dec_valid", 32'(bus.dec_valid), 32'(1));
        ready_mode = 1;
        cycle();
        ready_mode = 2;
        base = n_upd;
        repeat (30) cycle();
        chk("bp_one_more", 32'(n_upd - base), 32'(1));
        ready_mode = 1;
        repeat (12) cycle();

        // Delayed grant and read data
        gnt_delay = 3;
        rv_delay = 2;
        run_fetches(1, 30, "dly_sync");
        run_fetches(1, 30, "dly_done");
        chk("dly_period", 32'(last_upd_cyc - prev_upd_cyc), 32'(9));

        // Reset while waiting for read data, then late rvalid
        gnt_delay = 0;
        rv_delay = 6;
        ready_mode = 2;
        k = 0;
        while (!pending && k < 40) begin
            cycle();
            k++;
        end
        chk("rw_granted", 32'(pending), 32'(1));
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.reg_rdata = 16'hFFFF;
        reset = 1'b1;
        #1;
        chk("rw_wait_req", 32'(bus.mem_req), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        bus.pc_addr = pc;
        #1;
        check_reset_outputs("rw");
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        #1;
        chk("rw_late_dec", 32'(bus.dec_valid), 32'(0));
        chk("rw_req", 32'(bus.mem_req), 32'(1));
        chk("rw_addr", 32'(bus.mem_addr), 32'(pc));
        q.delete();
        pending = 1'b0;
        upd_due = 1'b0;
        gnt_cnt = 0;
        prev_req = 1'b1;
        prev_mem_addr = pc;
        prev_pc = pc;
        prev_qsize = 0;
        rv_delay = 0;

        // Randomized traffic
        ready_mode = 0;
        base = n_upd;
        for (int i = 0; i < 400; i++) begin
            gnt_delay = $urandom_range(0, 3);
            rv_delay = $urandom_range(0, 3);
            cycle();
        end
        chk("rand_progress", 32'(n_upd - base > 20), 32'(1));
        ready_mode = 1;
        gnt_delay = 0;
        rv_delay = 0;
        repeat (20) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
